// File: rtl/commit_trace_driver.sv
// Commit-trace transmit driver: packs handshaked retire records into RETIRE_W-wide commit bundles.
// Optional sequential-tag checker is enabled by defining COMMIT_DRV_TAG_CHECK_EN.
module commit_trace_driver #(
  parameter int RETIRE_W = 4,
  parameter int XLEN     = 64,
  parameter int VLEN     = 256,
  parameter int ADDR_W   = 40,
  parameter int LREG_W   = 5,
  parameter int TIMEOUT  = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_pc,
  input  logic [31:0]                  in_inst,
  input  logic [LREG_W-1:0]            in_ldst,
  input  logic [2:0]                   in_rtype,
  input  logic [63:0]                  in_tag,
  input  logic [XLEN-1:0]              in_wdata,
  input  logic [VLEN*8-1:0]            in_vec_wdata,
  input  logic [7:0]                   in_vec_wmask,
  input  logic                         in_flush,
  input  logic                         commit_en,
  output logic [RETIRE_W-1:0]          commit_valids,
  output logic [RETIRE_W*ADDR_W-1:0]   commit_pc,
  output logic [RETIRE_W*32-1:0]       commit_inst,
  output logic [RETIRE_W*LREG_W-1:0]   commit_ldst,
  output logic [RETIRE_W*3-1:0]        commit_rtype,
  output logic [RETIRE_W*64-1:0]       commit_tag,
  output logic [RETIRE_W*XLEN-1:0]     commit_wdata,
  output logic [RETIRE_W*VLEN*8-1:0]   commit_vec_wdata,
  output logic [RETIRE_W*8-1:0]        commit_vec_wmask,
  output logic [31:0]                  retired_cnt,
  output logic                         err_tag_seq
);

  localparam int VW    = VLEN * 8;
  localparam int CNT_W = $clog2(RETIRE_W + 1);
  localparam int IDX_W = (RETIRE_W > 1) ? $clog2(RETIRE_W) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0]    r_count;
  logic [TMR_W-1:0]    r_timer;
  logic                r_close_pend;

  logic [ADDR_W-1:0]   r_buf_pc    [RETIRE_W];
  logic [31:0]         r_buf_inst  [RETIRE_W];
  logic [LREG_W-1:0]   r_buf_ldst  [RETIRE_W];
  logic [2:0]          r_buf_rtype [RETIRE_W];
  logic [63:0]         r_buf_tag   [RETIRE_W];
  logic [XLEN-1:0]     r_buf_wdata [RETIRE_W];
  logic [VW-1:0]       r_buf_vec   [RETIRE_W];
  logic [7:0]          r_buf_wmask [RETIRE_W];

  logic                w_accept;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic                w_timeout;
  logic                w_trigger;
  logic                w_close;
  logic                w_set_pend;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [RETIRE_W-1:0] w_valids_nx;

  // Ready is gated by reset_n so it reads low for the whole time reset is held.
  assign in_ready   = reset_n && (r_count < CNT_W'(RETIRE_W));
  assign w_accept   = in_valid && in_ready;
  assign w_cnt_nx   = r_count + CNT_W'(w_accept);
  assign w_timeout  = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_trigger  = (w_cnt_nx == CNT_W'(RETIRE_W)) || (w_accept && in_flush) ||
                      r_close_pend || (!w_accept && w_timeout);
  assign w_close    = commit_en && (w_cnt_nx != '0) && w_trigger;
  assign w_set_pend = !commit_en && (w_cnt_nx != '0) &&
                      ((w_accept && in_flush) || (!w_accept && w_timeout));
  assign w_wr_idx   = r_count[IDX_W-1:0];

  always_comb begin
    w_valids_nx = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      w_valids_nx[i] = (CNT_W'(i) < w_cnt_nx);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count      <= '0;
      r_timer      <= '0;
      r_close_pend <= 1'b0;
    end else if (w_close) begin
      r_count      <= '0;
      r_timer      <= '0;
      r_close_pend <= 1'b0;
    end else begin
      r_count <= w_cnt_nx;
      if (w_accept || (r_count == '0)) begin
        r_timer <= '0;
      end else if (!w_timeout) begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (w_set_pend) begin
        r_close_pend <= 1'b1;
      end
    end
  end

  // A record accepted on the closing edge bypasses the buffer straight onto the bus.
  always_ff @(posedge clock) begin
    if (w_accept && !w_close) begin
      r_buf_pc[w_wr_idx]    <= in_pc;
      r_buf_inst[w_wr_idx]  <= in_inst;
      r_buf_ldst[w_wr_idx]  <= in_ldst;
      r_buf_rtype[w_wr_idx] <= in_rtype;
      r_buf_tag[w_wr_idx]   <= in_tag;
      r_buf_wdata[w_wr_idx] <= in_wdata;
      r_buf_vec[w_wr_idx]   <= in_vec_wdata;
      r_buf_wmask[w_wr_idx] <= in_vec_wmask;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      commit_valids    <= '0;
      commit_pc        <= '0;
      commit_inst      <= '0;
      commit_ldst      <= '0;
      commit_rtype     <= '0;
      commit_tag       <= '0;
      commit_wdata     <= '0;
      commit_vec_wdata <= '0;
      commit_vec_wmask <= '0;
      retired_cnt      <= '0;
    end else begin
      commit_valids <= w_close ? w_valids_nx : '0;
      if (w_close) begin
        retired_cnt <= retired_cnt + 32'(w_cnt_nx);
      end
      for (int i = 0; i < RETIRE_W; i++) begin
        if (w_close && (CNT_W'(i) < r_count)) begin
          commit_pc[i*ADDR_W +: ADDR_W]    <= r_buf_pc[i];
          commit_inst[i*32 +: 32]          <= r_buf_inst[i];
          commit_ldst[i*LREG_W +: LREG_W]  <= r_buf_ldst[i];
          commit_rtype[i*3 +: 3]           <= r_buf_rtype[i];
          commit_tag[i*64 +: 64]           <= r_buf_tag[i];
          commit_wdata[i*XLEN +: XLEN]     <= r_buf_wdata[i];
          commit_vec_wdata[i*VW +: VW]     <= r_buf_vec[i];
          commit_vec_wmask[i*8 +: 8]       <= r_buf_wmask[i];
        end else if (w_close && w_accept && (CNT_W'(i) == r_count)) begin
          commit_pc[i*ADDR_W +: ADDR_W]    <= in_pc;
          commit_inst[i*32 +: 32]          <= in_inst;
          commit_ldst[i*LREG_W +: LREG_W]  <= in_ldst;
          commit_rtype[i*3 +: 3]           <= in_rtype;
          commit_tag[i*64 +: 64]           <= in_tag;
          commit_wdata[i*XLEN +: XLEN]     <= in_wdata;
          commit_vec_wdata[i*VW +: VW]     <= in_vec_wdata;
          commit_vec_wmask[i*8 +: 8]       <= in_vec_wmask;
        end else begin
          commit_pc[i*ADDR_W +: ADDR_W]    <= '0;
          commit_inst[i*32 +: 32]          <= '0;
          commit_ldst[i*LREG_W +: LREG_W]  <= '0;
          commit_rtype[i*3 +: 3]           <= '0;
          commit_tag[i*64 +: 64]           <= '0;
          commit_wdata[i*XLEN +: XLEN]     <= '0;
          commit_vec_wdata[i*VW +: VW]     <= '0;
          commit_vec_wmask[i*8 +: 8]       <= '0;
        end
      end
    end
  end

`ifdef COMMIT_DRV_TAG_CHECK_EN
  logic [63:0] r_prev_tag;
  logic        r_tag_seen;
  logic        r_err_tag;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_tag <= '0;
      r_tag_seen <= 1'b0;
      r_err_tag  <= 1'b0;
    end else if (w_accept) begin
      if (r_tag_seen && (in_tag != r_prev_tag + 64'd1)) begin
        r_err_tag <= 1'b1;
      end
      r_prev_tag <= in_tag;
      r_tag_seen <= 1'b1;
    end
  end

  assign err_tag_seq = r_err_tag;
`else
  assign err_tag_seq = 1'b0;
`endif

endmodule
